// File: rtl/color_pkg.sv
// Shared encodings for the Color FSM and its initiator-side driver.
// Status/command codes, driver state enum and the colour-to-status mapping.
package color_pkg;

    localparam logic [1:0] STATUS_BLUE = 2'h1;
    localparam logic [1:0] STATUS_RED  = 2'h2;

    localparam logic [1:0] CMD_HOLD    = 2'h0;
    localparam logic [1:0] CMD_TOGGLE  = 2'h1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_PULSE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } drv_state_e;

    function automatic logic [1:0] color_to_status(input logic color);
        return color ? STATUS_RED : STATUS_BLUE;
    endfunction

    function automatic logic status_is_valid(input logic [1:0] status);
        return (status == STATUS_BLUE) || (status == STATUS_RED);
    endfunction

endpackage

// File: rtl/color_fsm_driver_if.sv
// Request/response channel between the system sequencer and the colour driver.
// master = sequencer side, slave = driver side.
interface color_fsm_driver_if;

    logic req_valid;
    logic req_ready;
    logic req_color;
    logic resp_valid;
    logic resp_ready;
    logic resp_err;

    modport master (
        output req_valid,
        output req_color,
        output resp_ready,
        input  req_ready,
        input  resp_valid,
        input  resp_err
    );

    modport slave (
        input  req_valid,
        input  req_color,
        input  resp_ready,
        output req_ready,
        output resp_valid,
        output resp_err
    );

endinterface

// File: rtl/color_wait_timer.sv
// Load/count-down timer; expired is high during the last of the `value` cycles after load.
// Latency: load takes effect on the next edge; no backpressure.
module color_wait_timer #(
    parameter int TIMEOUT = 4,
    parameter int W       = $clog2(TIMEOUT + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expired
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = value;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Count==1 marks the final waiting cycle, so a load of N gives exactly N wait cycles.
    assign expired = (cnt_q == W'(1));

endmodule

// File: rtl/color_fsm_driver.sv
// Drives the Color FSM to a requested colour, retrying toggles on timeout, and reports done/error.
// Latency 2 (at target) / 4 (one toggle); req_ready low and resp held until resp_ready.
module color_fsm_driver
    import color_pkg::*;
#(
    parameter int TIMEOUT   = 4,
    parameter int MAX_RETRY = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    color_fsm_driver_if.slave   bus,
    output logic [1:0]          cmd,
    input  logic [1:0]          status,
    output logic [7:0]          toggle_cnt
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    drv_state_e    state_q;
    drv_state_e    state_d;
    logic [1:0]    target_q;
    logic [1:0]    target_d;
    logic [RW-1:0] retry_q;
    logic [RW-1:0] retry_d;
    logic [1:0]    cmd_q;
    logic [1:0]    cmd_d;
    logic          resp_valid_q;
    logic          resp_valid_d;
    logic          resp_err_q;
    logic          resp_err_d;
    logic [7:0]    toggle_cnt_q;
    logic [7:0]    toggle_cnt_d;

    logic          timer_load;
    logic          timer_expired;
    logic          status_match;

    assign status_match = (status == target_q);

    color_wait_timer #(
        .TIMEOUT (TIMEOUT),
        .W       (TW)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (timer_load),
        .value   (TW'(TIMEOUT)),
        .expired (timer_expired)
    );

    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        retry_d      = retry_q;
        resp_err_d   = resp_err_q;
        toggle_cnt_d = toggle_cnt_q;
        timer_load   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    target_d = color_to_status(bus.req_color);
                    retry_d  = '0;
                    state_d  = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (status_match) begin
                    resp_err_d = 1'b0;
                    state_d    = ST_RESP;
                end else if (!status_is_valid(status)) begin
                    resp_err_d = 1'b1;
                    state_d    = ST_RESP;
                end else begin
                    state_d    = ST_PULSE;
                end
            end
            ST_PULSE: begin
                timer_load = 1'b1;
                if (toggle_cnt_q != 8'hFF) begin
                    toggle_cnt_d = toggle_cnt_q + 8'd1;
                end
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A match seen in the expiry cycle still counts as success.
                if (status_match) begin
                    resp_err_d = 1'b0;
                    state_d    = ST_RESP;
                end else if (timer_expired) begin
                    if (retry_q < RW'(MAX_RETRY)) begin
                        retry_d = retry_q + RW'(1);
                        state_d = ST_PULSE;
                    end else begin
                        resp_err_d = 1'b1;
                        state_d    = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered outputs follow the next state so they line up with it.
        cmd_d        = (state_d == ST_PULSE) ? CMD_TOGGLE : CMD_HOLD;
        resp_valid_d = (state_d == ST_RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            target_q     <= STATUS_BLUE;
            retry_q      <= '0;
            cmd_q        <= CMD_HOLD;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            toggle_cnt_q <= 8'h00;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            retry_q      <= retry_d;
            cmd_q        <= cmd_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            toggle_cnt_q <= toggle_cnt_d;
        end
    end

    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign cmd            = cmd_q;
    assign toggle_cnt     = toggle_cnt_q;

    a_cmd_legal: assert property (@(posedge clk) disable iff (!rst_n)
        (cmd_q == CMD_HOLD) || (cmd_q == CMD_TOGGLE));

    a_resp_held: assert property (@(posedge clk) disable iff (!rst_n)
        (resp_valid_q && !bus.resp_ready) |=> (resp_valid_q && $stable(resp_err_q)));

endmodule

// File: tb/tb_color_fsm_driver.sv
// Bench for color_fsm_driver: a behavioural Color FSM plant plus a per-cycle reference model.
// Directed scenarios pin latencies/counts with literals; a random phase mixes plant behaviours.
module tb_color_fsm_driver;
    import color_pkg::*;

    localparam int TO = 4;
    localparam int MR = 2;
    localparam int SP = TO + 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] cmd;
    logic [1:0] fsm_status;
    logic [7:0] toggle_cnt;

    color_fsm_driver_if bus ();

    color_fsm_driver #(
        .TIMEOUT   (TO),
        .MAX_RETRY (MR)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .cmd        (cmd),
        .status     (fsm_status),
        .toggle_cnt (toggle_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Plant: mode 0 = working FSM (flips pl_delay cycles after a toggle), mode 1 = status forced.
    int         pl_mode;
    logic [1:0] pl_base;
    logic [1:0] pl_force;
    int         pl_delay;
    logic       pl_flip;
    int         pl_pend;

    // Reference model of one outstanding transaction.
    logic       m_busy;
    logic       m_sched;
    logic       m_err;
    logic [1:0] m_tgt;
    int         m_h;
    int         m_resp;
    int         m_p0;
    int         m_np;
    int         m_tcnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit is_pulse(input int x);
        if (!(m_busy && m_sched) || m_np == 0 || x < m_p0) return 1'b0;
        return ((x - m_p0) % SP == 0) && ((x - m_p0) / SP < m_np);
    endfunction

    task automatic cycle_loop();
        forever begin
            @(posedge clk);
            cyc++;
        end
    endtask

    task automatic monitor_loop();
        logic       exp_rv;
        logic [1:0] exp_cmd;
        logic [1:0] s;
        forever begin
            @(negedge clk);
            if (pl_mode == 1) begin
                fsm_status = pl_force;
            end else begin
                if (pl_pend > 0) begin
                    pl_pend--;
                    if (pl_pend == 0) pl_flip = ~pl_flip;
                end
                if (cmd == 2'h1) pl_pend = pl_delay;
                fsm_status = pl_base ^ {pl_flip, pl_flip};
            end

            if (!rst_n) begin
                m_busy  = 1'b0;
                m_sched = 1'b0;
                m_tcnt  = 0;
                chk("rst_req_ready", bus.req_ready, 1);
                chk("rst_resp_valid", bus.resp_valid, 0);
                chk("rst_resp_err", bus.resp_err, 0);
                chk("rst_cmd", cmd, 0);
                chk("rst_toggle_cnt", toggle_cnt, 0);
            end else begin
                exp_rv  = m_busy && m_sched && (cyc >= m_resp);
                exp_cmd = is_pulse(cyc) ? 2'h1 : 2'h0;
                chk("req_ready", bus.req_ready, !m_busy);
                chk("resp_valid", bus.resp_valid, exp_rv);
                chk("cmd", cmd, exp_cmd);
                chk("toggle_cnt", toggle_cnt, m_tcnt);
                if (exp_rv) chk("resp_err", bus.resp_err, m_err);

                if (is_pulse(cyc) && m_tcnt < 255) m_tcnt++;
                if (!m_busy) begin
                    if (bus.req_valid) begin
                        m_busy  = 1'b1;
                        m_sched = 1'b0;
                        m_h     = cyc;
                        m_tgt   = bus.req_color ? 2'h2 : 2'h1;
                    end
                end else if (!m_sched) begin
                    s       = fsm_status;
                    m_sched = 1'b1;
                    m_p0    = m_h + 2;
                    if (s == m_tgt) begin
                        m_np = 0; m_resp = m_h + 2; m_err = 1'b0;
                    end else if (s == 2'h0 || s == 2'h3) begin
                        m_np = 0; m_resp = m_h + 2; m_err = 1'b1;
                    end else if (pl_mode == 0) begin
                        m_np = 1; m_resp = m_h + 3 + pl_delay; m_err = 1'b0;
                    end else begin
                        m_np = MR + 1; m_resp = m_h + 2 + (MR + 1) * SP; m_err = 1'b1;
                    end
                end else if (exp_rv && bus.resp_ready) begin
                    m_busy  = 1'b0;
                    m_sched = 1'b0;
                end
            end
        end
    endtask

    task automatic set_normal(input logic [1:0] v, input int d);
        pl_mode  = 0;
        pl_base  = v ^ {pl_flip, pl_flip};
        pl_delay = d;
    endtask

    task automatic set_stuck(input logic [1:0] v);
        pl_mode  = 1;
        pl_force = v;
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after the response handshake.
    task automatic txn(input logic color, input int hold, input bit keep,
                       output int lat, output logic err, output int hs, output int rc);
        int g;
        bus.req_valid = 1'b1;
        bus.req_color = color;
        g = 0;
        do begin @(negedge clk); g++; end while (!bus.req_ready && g < 100);
        chk("req_accepted", bus.req_ready, 1);
        hs = cyc;
        @(posedge clk); #1;
        if (!keep) bus.req_valid = 1'b0;
        g = 0;
        do begin @(negedge clk); g++; end while (!bus.resp_valid && g < 200);
        chk("resp_arrived", bus.resp_valid, 1);
        lat = cyc - hs;
        err = bus.resp_err;
        repeat (hold) begin @(posedge clk); #1; end
        @(posedge clk); #1;
        bus.resp_ready = 1'b1;
        rc = cyc;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Reset asserted mid-transaction, `at` cycles after the request handshake.
    task automatic reset_during(input int at);
        int g;
        set_stuck(2'h2);
        bus.req_valid = 1'b1;
        bus.req_color = 1'b0;
        g = 0;
        do begin @(negedge clk); g++; end while (!bus.req_ready && g < 100);
        chk("rst_test_accept", bus.req_ready, 1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (at - 1) begin @(posedge clk); #1; end
        if (at == 2) chk("pulse_before_reset", cmd, 2'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_cmd", cmd, 0);
        chk("async_resp_valid", bus.resp_valid, 0);
        chk("async_toggle_cnt", toggle_cnt, 0);
        chk("async_req_ready", bus.req_ready, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_req_ready", bus.req_ready, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        int   lat;
        int   hs;
        int   rc;
        int   rc1;
        logic err;

        rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_color  = 1'b0;
        bus.resp_ready = 1'b0;
        pl_flip        = 1'b0;
        pl_pend        = 0;
        pl_force       = 2'h2;
        m_busy         = 1'b0;
        m_sched        = 1'b0;
        m_tcnt         = 0;
        set_normal(2'h2, 1);

        fork
            cycle_loop();
            monitor_loop();
        join_none

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset_req_ready", bus.req_ready, 1);
        chk("reset_resp_valid", bus.resp_valid, 0);
        chk("reset_cmd", cmd, 0);
        chk("reset_toggle_cnt", toggle_cnt, 0);

        // FSM already Red, request Red
        txn(1'b1, 0, 1'b0, lat, err, hs, rc);
        chk("at_target_latency", lat, 2);
        chk("at_target_err", err, 0);
        chk("at_target_toggles", toggle_cnt, 0);

        // FSM Red, request Blue: one toggle
        txn(1'b0, 0, 1'b0, lat, err, hs, rc);
        chk("one_toggle_latency", lat, 4);
        chk("one_toggle_err", err, 0);
        chk("one_toggle_toggles", toggle_cnt, 1);
        chk("one_toggle_status", fsm_status, 2'h1);

        apply_reset();
        chk("reset2_toggle_cnt", toggle_cnt, 0);

        // Status stuck Red, request Blue: all retries used
        set_stuck(2'h2);
        txn(1'b0, 0, 1'b0, lat, err, hs, rc);
        chk("stuck_latency", lat, 17);
        chk("stuck_err", err, 1);
        chk("stuck_toggles", toggle_cnt, 3);

        // Invalid status
        set_stuck(2'h3);
        txn(1'b1, 0, 1'b0, lat, err, hs, rc);
        chk("invalid_latency", lat, 2);
        chk("invalid_err", err, 1);
        chk("invalid_toggles", toggle_cnt, 3);

        // Response backpressure with a request waiting behind it
        set_normal(2'h1, 1);
        txn(1'b1, 10, 1'b1, lat, err, hs, rc1);
        chk("bp_latency", lat, 4);
        chk("bp_err", err, 0);
        txn(1'b0, 0, 1'b0, lat, err, hs, rc);
        chk("bp_next_accept_gap", hs - rc1, 1);
        chk("bp_next_latency", lat, 4);
        chk("bp_toggles", toggle_cnt, 5);

        // Status changes exactly in the expiry cycle: match wins
        set_normal(2'h1, TO);
        txn(1'b1, 0, 1'b0, lat, err, hs, rc);
        chk("late_match_latency", lat, 3 + TO);
        chk("late_match_err", err, 0);

        for (int i = 0; i < 60; i++) begin
            int  mode;
            bit  keep;
            mode = $urandom_range(0, 3);
            case (mode)
                0, 1: set_normal($urandom_range(0, 1) ? 2'h2 : 2'h1, $urandom_range(1, TO));
                2:    set_stuck($urandom_range(0, 1) ? 2'h2 : 2'h1);
                default: set_stuck($urandom_range(0, 1) ? 2'h3 : 2'h0);
            endcase
            keep = ($urandom_range(0, 3) == 0);
            txn(1'($urandom_range(0, 1)), $urandom_range(0, 3), keep, lat, err, hs, rc);
            if (!keep) begin
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
        end
        bus.req_valid = 1'b0;
        @(posedge clk); #1;

        reset_during(4);
        reset_during(2);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/color_fsm_driver.md
# color_fsm_driver

Initiator-side controller for the two-state Color FSM (Blue/Red). It accepts "go to colour X" requests on a valid/ready channel and drives the FSM's 2-bit command input. It watches the FSM's 2-bit status output, retries on timeout, and returns a completion/error response. It sits between the system sequencer and the Color FSM, on the opposite end of the FSM's `in`/`out` pair.

## Interface
Parameters:
- TIMEOUT, default 4: cycles to wait for the status to change after a toggle pulse (≥1).
- MAX_RETRY, default 2: extra toggle pulses allowed after the first timeout (≥0).

Ports:
- clk  input  1  clock; all state on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted when both are high.
- req_color  input  1  target colour: 0 = Blue, 1 = Red.
- resp_valid  output  1  response present; held until accepted.
- resp_ready  input  1  response consumed when both are high.
- resp_err  output  1  1 = target not reached or status invalid.
- cmd  output  2  drives the FSM `in` port.
- status  input  2  from the FSM `out` port: 2'h1 = Blue, 2'h2 = Red; 2'h0 and 2'h3 are invalid.
- toggle_cnt  output  8  saturating count of toggle pulses issued since reset.

## Operation
- Command codes:
  - CMD_HOLD = 2'h0 keeps the FSM in either state.
  - CMD_TOGGLE = 2'h1 flips it.
  - The driver only ever emits these two codes.
- States: IDLE, CHECK, PULSE, WAIT, RESP.
- IDLE:
  - req_ready = 1, cmd = HOLD.
  - On a handshake, latch the target code (Blue → 2'h1, Red → 2'h2), clear the retry counter, and go to CHECK.
- CHECK:
  - If status equals the target, set resp_err = 0 and go to RESP. No pulse is issued.
  - If status is invalid, set resp_err = 1 and go to RESP.
  - Otherwise go to PULSE.
- PULSE:
  - cmd = TOGGLE for exactly one cycle.
  - toggle_cnt increments, saturating at 8'hFF.
  - Load the wait timer with TIMEOUT and go to WAIT.
- WAIT:
  - cmd = HOLD. Status is compared to the target every cycle.
  - On a match, set resp_err = 0 and go to RESP, even if the timer expires in the same cycle (match wins).
  - On expiry with retries < MAX_RETRY, increment retries and go to PULSE.
  - On expiry otherwise, set resp_err = 1 and go to RESP.
- RESP:
  - resp_valid = 1; resp_err is stable.
  - On resp_ready, go to IDLE.
  - req_ready stays 0 until IDLE, so requests are never accepted while a response is pending.
- toggle_cnt is cleared only by reset.

## Timing
- Reset values:
  - State IDLE, so req_ready = 1.
  - resp_valid = 0, resp_err = 0, cmd = 2'h0, toggle_cnt = 0.
  - Timer and retry counters are 0.
- cmd, resp_valid and resp_err are registered outputs. req_ready is decoded from the state register.
- The FSM samples cmd on the edge after PULSE, so the new status is visible one cycle after the PULSE cycle, i.e. in the first WAIT cycle.
- Latencies from request handshake to resp_valid:
  - Already at target: 2 cycles (CHECK, then RESP).
  - One toggle with a normal FSM: 4 cycles (CHECK, PULSE, WAIT, then RESP).
  - Fully failing: 2 + (MAX_RETRY+1)·(1+TIMEOUT) cycles.
- Reset mid-operation:
  - cmd returns to HOLD asynchronously.
  - Any latched request and pending response are discarded.
  - toggle_cnt clears.
- A request arriving in the same cycle as the response handshake is not accepted. It is accepted one cycle later, in IDLE.

## Structure
- Shared package `color_pkg`:
  - status codes STATUS_BLUE = 2'h1, STATUS_RED = 2'h2;
  - command codes CMD_HOLD, CMD_TOGGLE;
  - the driver state enum;
  - a colour-to-status-code function.
- The Color FSM should also import the status codes from this package.
- Sub-module `color_wait_timer`:
  - load/count-down timer, width $clog2(TIMEOUT+1);
  - inputs load and value; output expired;
  - asynchronous active-low reset.

## Test plan
- Reset with the FSM in Red (status 2'h2); request Red → resp_valid 2 cycles after the handshake, resp_err = 0, no cmd pulse, toggle_cnt = 0.
- Request Blue with the FSM in Red → exactly one cycle of cmd = 2'h1, status reads 2'h1 in the next cycle, resp_err = 0 at +4 cycles, toggle_cnt = 1.
- Status forced stuck at 2'h2, TIMEOUT = 4, MAX_RETRY = 2, request Blue → 3 toggle pulses spaced 5 cycles apart, resp_err = 1 at +17 cycles, toggle_cnt = 3.
- Status forced to 2'h3, request Red → resp_err = 1 at +2 cycles, no pulse issued.
- Hold resp_ready = 0 for 10 cycles while req_valid = 1 → resp_valid and resp_err stay stable and req_ready stays 0; the next request is accepted one cycle after the resp handshake.
- Assert rst_n low during WAIT → cmd = 0, resp_valid = 0 and toggle_cnt = 0 immediately; after release, req_ready = 1.
